// File: rtl/hamming_decoder32.sv
// SEC-DED decoder for 26->32-bit Hamming codewords.
// Two-stage valid/ready pipeline with saturating error counters.
module hamming_decoder32 #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      code_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [25:0]      data_out,
    output logic             err_single,
    output logic             err_double,
    output logic [4:0]       syndrome_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [4:0] calc_syn(input logic [30:0] c);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < 31; i++) begin
            if (c[i]) s = s ^ 5'(i + 1);
        end
        return s;
    endfunction

    // Data bits occupy every non-power-of-two position, ascending.
    function automatic logic [25:0] extract(input logic [30:0] c);
        logic [25:0] d;
        logic [4:0]  k;
        d = '0;
        k = '0;
        for (int i = 0; i < 31; i++) begin
            if (((i + 1) & i) != 0) begin
                d[k] = c[i];
                k    = k + 5'd1;
            end
        end
        return d;
    endfunction

    logic        s1_valid;
    logic [30:0] s1_code;
    logic [4:0]  s1_syn;
    logic        s1_ovp;

    logic        s2_load;
    logic        handshake;
    logic [4:0]  in_syn;
    logic        in_ovp;
    logic [30:0] fixed;
    logic [25:0] fix_data;
    logic        fix_single;
    logic        fix_double;

    assign s2_load   = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign handshake = out_valid && out_ready;
    assign in_syn    = calc_syn(code_in[30:0]);
    assign in_ovp    = ^code_in;

    always_comb begin
        fixed      = s1_code;
        fix_single = s1_ovp;
        fix_double = !s1_ovp && (s1_syn != 5'd0);
        // s==0 with odd parity means only bit 31 was hit
        if (s1_ovp && (s1_syn != 5'd0)) begin
            fixed[s1_syn - 5'd1] = ~s1_code[s1_syn - 5'd1];
        end
        fix_data = extract(fixed);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_ovp   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= code_in[30:0];
                s1_syn  <= in_syn;
                s1_ovp  <= in_ovp;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            err_single   <= 1'b0;
            err_double   <= 1'b0;
            syndrome_out <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out     <= fix_data;
                err_single   <= fix_single;
                err_double   <= fix_double;
                syndrome_out <= s1_syn;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (clear_counts) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (handshake) begin
            if (err_single && (corr_count != '1)) begin
                corr_count <= corr_count + CNT_ONE;
            end
            if (err_double && (uncorr_count != '1)) begin
                uncorr_count <= uncorr_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hamming_decoder32.sv
// Directed-vector bench for hamming_decoder32.
// Counters are built 3 bits wide so saturation is reachable quickly.
module tb_hamming_decoder32;

    logic        clock;
    logic        reset;
    logic [31:0] code_in;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] data_out;
    logic        err_single;
    logic        err_double;
    logic [4:0]  syndrome_out;
    logic        out_valid;
    logic        out_ready;
    logic        clear_counts;
    logic [2:0]  corr_count;
    logic [2:0]  uncorr_count;

    int checks;
    int errors;

    hamming_decoder32 #(.CNT_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .code_in      (code_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .err_single   (err_single),
        .err_double   (err_double),
        .syndrome_out (syndrome_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .clear_counts (clear_counts),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Push one word with out_ready high and wait until it shows.
    task automatic send(input logic [31:0] c);
        bit seen;
        in_valid  = 1'b1;
        code_in   = c;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL send_timeout: code %h never reached out_valid", c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, err_single, err_double} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 000",
                     {out_valid, err_single, err_double});
        end
        checks++;
        if ({data_out, syndrome_out} !== 31'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h exp 0/0",
                     data_out, syndrome_out);
        end
        checks++;
        if ({corr_count, uncorr_count} !== 6'h0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d exp 0/0",
                     corr_count, uncorr_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b exp 1", in_ready);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b exp 1", in_ready);
        end
    endtask

    task automatic test_latency();
        in_valid  = 1'b1;
        code_in   = 32'h80000007;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid %b exp 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || data_out !== 26'h1) begin
            errors++;
            $display("FAIL latency_out: got v=%b d=%h exp v=1 d=1",
                     out_valid, data_out);
        end
        checks++;
        if ({err_single, err_double, syndrome_out} !== 7'h0) begin
            errors++;
            $display("FAIL latency_flags: got %b%b/%h exp 00/0",
                     err_single, err_double, syndrome_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_dup: got out_valid %b exp 0", out_valid);
        end
    endtask

    task automatic test_clean();
        send(32'h00000000);
        checks++;
        if ({data_out, err_single, err_double, syndrome_out} !== 33'h0) begin
            errors++;
            $display("FAIL clean_zero: got d=%h s=%b d=%b syn=%h exp 0",
                     data_out, err_single, err_double, syndrome_out);
        end
        send(32'h4000808B);
        checks++;
        if (data_out !== 26'h2000000 || err_single || err_double) begin
            errors++;
            $display("FAIL clean_top: got d=%h s=%b d=%b exp 2000000/0/0",
                     data_out, err_single, err_double);
        end
        tick();
        checks++;
        if ({corr_count, uncorr_count} !== 6'h0) begin
            errors++;
            $display("FAIL clean_counts: got %0d/%0d exp 0/0",
                     corr_count, uncorr_count);
        end
    endtask

    task automatic test_single();
        send(32'h80000027);
        checks++;
        if (data_out !== 26'h1 || err_single !== 1'b1 ||
            err_double !== 1'b0 || syndrome_out !== 5'd6) begin
            errors++;
            $display("FAIL single_bit5: got d=%h s=%b d=%b syn=%0d exp 1/1/0/6",
                     data_out, err_single, err_double, syndrome_out);
        end
        tick();
        checks++;
        if (corr_count !== 3'd1) begin
            errors++;
            $display("FAIL single_count1: got %0d exp 1", corr_count);
        end
        send(32'h0000808B);
        checks++;
        if (data_out !== 26'h2000000 || err_single !== 1'b1 ||
            syndrome_out !== 5'd31) begin
            errors++;
            $display("FAIL single_bit30: got d=%h s=%b syn=%0d exp 2000000/1/31",
                     data_out, err_single, syndrome_out);
        end
        tick();
        send(32'h80008007);
        checks++;
        if (data_out !== 26'h1 || err_single !== 1'b1 ||
            syndrome_out !== 5'd16) begin
            errors++;
            $display("FAIL single_parity16: got d=%h s=%b syn=%0d exp 1/1/16",
                     data_out, err_single, syndrome_out);
        end
        tick();
        checks++;
        if (corr_count !== 3'd3) begin
            errors++;
            $display("FAIL single_count3: got %0d exp 3", corr_count);
        end
    endtask

    task automatic test_bit31();
        send(32'h00000007);
        checks++;
        if (data_out !== 26'h1 || err_single !== 1'b1 ||
            err_double !== 1'b0 || syndrome_out !== 5'd0) begin
            errors++;
            $display("FAIL bit31: got d=%h s=%b d=%b syn=%0d exp 1/1/0/0",
                     data_out, err_single, err_double, syndrome_out);
        end
        tick();
        checks++;
        if (corr_count !== 3'd4) begin
            errors++;
            $display("FAIL bit31_count: got %0d exp 4", corr_count);
        end
    endtask

    task automatic test_double();
        send(32'h80000004);
        checks++;
        if (err_double !== 1'b1 || err_single !== 1'b0 ||
            syndrome_out !== 5'd3 || data_out !== 26'h1) begin
            errors++;
            $display("FAIL double: got d=%h s=%b d=%b syn=%0d exp 1/0/1/3",
                     data_out, err_single, err_double, syndrome_out);
        end
        tick();
        checks++;
        if (uncorr_count !== 3'd1 || corr_count !== 3'd4) begin
            errors++;
            $display("FAIL double_counts: got %0d/%0d exp 4/1",
                     corr_count, uncorr_count);
        end
    endtask

    task automatic test_saturate();
        in_valid  = 1'b1;
        code_in   = 32'h80000027;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (corr_count !== 3'd7) begin
            errors++;
            $display("FAIL saturate: got %0d exp 7", corr_count);
        end
    endtask

    task automatic test_clear();
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        checks++;
        if ({corr_count, uncorr_count} !== 6'h0) begin
            errors++;
            $display("FAIL clear: got %0d/%0d exp 0/0",
                     corr_count, uncorr_count);
        end
        send(32'h80000027);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        checks++;
        if (corr_count !== 3'd0) begin
            errors++;
            $display("FAIL clear_vs_inc: got %0d exp 0", corr_count);
        end
        send(32'h80000027);
        tick();
        checks++;
        if (corr_count !== 3'd1) begin
            errors++;
            $display("FAIL clear_then_inc: got %0d exp 1", corr_count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = 32'h80000007;
        tick();
        code_in = 32'h00000000;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_w2: got %b exp 1", in_ready);
        end
        tick();
        code_in = 32'h80000019;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall: got rdy=%b v=%b exp 0/1",
                     in_ready, out_valid);
        end
        tick();
        checks++;
        if (data_out !== 26'h1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: got d=%h v=%b rdy=%b exp 1/1/0",
                     data_out, out_valid, in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release_ready: got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || data_out !== 26'h0) begin
            errors++;
            $display("FAIL b2b_word2: got v=%b d=%h exp 1/0",
                     out_valid, data_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || data_out !== 26'h2) begin
            errors++;
            $display("FAIL b2b_word3: got v=%b d=%h exp 1/2",
                     out_valid, data_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit stale;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = 32'h80000027;
        tick();
        code_in = 32'h80000004;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 26'h0 ||
            err_single !== 1'b0 || syndrome_out !== 5'd0) begin
            errors++;
            $display("FAIL midreset_out: got v=%b d=%h s=%b syn=%0d exp 0",
                     out_valid, data_out, err_single, syndrome_out);
        end
        checks++;
        if (in_ready !== 1'b1 || corr_count !== 3'd0) begin
            errors++;
            $display("FAIL midreset_state: got rdy=%b cnt=%0d exp 1/0",
                     in_ready, corr_count);
        end
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL midreset_stale: got stale word exp none");
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        code_in      = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        clear_counts = 1'b0;
        test_reset();
        test_latency();
        test_clean();
        test_single();
        test_bit31();
        test_double();
        test_saturate();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
